// File: rtl/pipe_adder_pkg.sv
// Shared constants, chunk-width helper and the per-stage payload carried down the adder pipeline.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  // Payload vectors are sized for the widest supported operand (WIDTH <= 64); bits above WIDTH stay 0.
  localparam int PAYLOAD_W  = 64;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] a_hi;    // unconsumed chunks of a, current chunk at the LSBs
    logic [PAYLOAD_W-1:0] b_hi;    // unconsumed chunks of b (already inverted for sub)
    logic [PAYLOAD_W-1:0] res_lo;  // finished result chunks, each at its final bit position
    logic                 cin;
    logic                 sub;
  } payload_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One chunk of the pipelined adder: a CW-bit add of chunk IDX, its pipeline register and its valid/advance logic.
module pipe_adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int CW  = 8,
  parameter int IDX = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush_i,
  input  logic     load_i,
  input  logic     down_ready_i,
  input  payload_t pl_i,
  output logic     ready_o,
  output logic     valid_o,
  output logic     adv_o,
  output payload_t pl_o,
  output logic     ovf_o
);

  logic     valid_q;
  payload_t pl_q;
  logic     ovf_q;
  payload_t pl_d;
  logic     ovf_d;
  logic [CW:0] sum;

  always_comb begin
    sum         = {1'b0, pl_i.a_hi[CW-1:0]} + {1'b0, pl_i.b_hi[CW-1:0]} + {{CW{1'b0}}, pl_i.cin};
    pl_d        = pl_i;
    pl_d.a_hi   = pl_i.a_hi >> CW;
    pl_d.b_hi   = pl_i.b_hi >> CW;
    pl_d.res_lo = pl_i.res_lo | (PAYLOAD_W'(sum[CW-1:0]) << (IDX * CW));
    pl_d.cin    = sum[CW];
    // Carry into this chunk's MSB is recovered from the MSB sum bit; only the last slice's value is used.
    ovf_d       = sum[CW] ^ pl_i.a_hi[CW-1] ^ pl_i.b_hi[CW-1] ^ sum[CW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (flush_i)     valid_q <= 1'b0;
      else if (load_i) valid_q <= 1'b1;
      else if (adv_o)  valid_q <= 1'b0;
      if (load_i && !flush_i) begin
        pl_q  <= pl_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign adv_o   = valid_q & down_ready_i;
  assign ready_o = ~valid_q | down_ready_i;
  assign valid_o = valid_q;
  assign pl_o    = pl_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipe_adder.sv
// Elastic STAGES-deep add/subtract unit with valid/ready on both sides and a squash input.
// Optional signed saturation on overflow is built when PIPE_ADDER_SAT_EN is defined.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  payload_t         pl_in;
  payload_t         pl_out [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_adv;
  logic [STAGES-1:0] stage_rdy;
  logic [STAGES-1:0] stage_ovf;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] down_ready;
  logic [WIDTH-1:0]  res_wrap;

  // Subtraction is a + ~b + 1: invert b here and seed chunk 0 with carry-in 1.
  always_comb begin
    pl_in        = '0;
    pl_in.a_hi   = PAYLOAD_W'(a);
    pl_in.b_hi   = PAYLOAD_W'(b ^ {WIDTH{sub}});
    pl_in.cin    = sub;
    pl_in.sub    = sub;
  end

  assign in_ready = ~flush & stage_rdy[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_load[gi] = in_valid & in_ready;
    end else begin : g_mid
      assign stage_load[gi] = stage_adv[gi-1];
    end

    if (gi == STAGES - 1) begin : g_last
      assign down_ready[gi] = out_ready;
    end else begin : g_inner
      assign down_ready[gi] = stage_rdy[gi+1];
    end

    pipe_adder_slice #(
      .CW  (CW),
      .IDX (gi)
    ) u_slice (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush),
      .load_i       (stage_load[gi]),
      .down_ready_i (down_ready[gi]),
      .pl_i         ((gi == 0) ? pl_in : pl_out[(gi == 0) ? 0 : gi-1]),
      .ready_o      (stage_rdy[gi]),
      .valid_o      (stage_valid[gi]),
      .adv_o        (stage_adv[gi]),
      .pl_o         (pl_out[gi]),
      .ovf_o        (stage_ovf[gi])
    );
  end

  assign res_wrap  = pl_out[STAGES-1].res_lo[WIDTH-1:0];
  assign out_valid = stage_valid[STAGES-1];
  assign carry     = pl_out[STAGES-1].cin;
  assign overflow  = stage_ovf[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
  // On overflow the wrapped sign is the opposite of the true sign.
  assign result = !overflow      ? res_wrap :
                  res_wrap[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign result = res_wrap;
`endif

  logic unused_tail;
  assign unused_tail = ^{pl_out[STAGES-1], stage_ovf, stage_valid, stage_adv[STAGES-1]};

endmodule
